// File: rtl/if_stage_if.sv
// ============================================================================
//  if_stage_if
//  Fetch-stage bundle: hazard/redirect controls, I-cache port, IF/ID outputs.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface if_stage_if;
    logic        PCWrite;
    logic        if_id_Write;
    logic        dcache_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic        ICACHE_stall;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic [5:0]  opcode_ID;

    modport master (
        input  PCWrite, if_id_Write, dcache_stall, redirect_valid, redirect_pc,
        input  ICACHE_rdata, ICACHE_stall,
        output ICACHE_ren, ICACHE_addr,
        output if_id_pc_plus4, if_id_inst, if_id_valid, if_id_rs, if_id_rt, opcode_ID
    );

    modport slave (
        output PCWrite, if_id_Write, dcache_stall, redirect_valid, redirect_pc,
        output ICACHE_rdata, ICACHE_stall,
        input  ICACHE_ren, ICACHE_addr,
        input  if_id_pc_plus4, if_id_inst, if_id_valid, if_id_rs, if_id_rt, opcode_ID
    );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
//  if_stage
//  MIPS instruction fetch (PC, I-cache request) and IF/ID pipeline register.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    if_stage_if.master   bus
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]  state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] pc4_q,     pc4_d;
    logic [31:0] inst_q,    inst_d;
    logic        valid_q,   valid_d;

    logic        w_accept;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // A redirect is only taken when the PC is allowed to move this cycle.
    assign w_accept   = bus.redirect_valid & ~bus.dcache_stall & bus.PCWrite;
    assign w_target   = bus.redirect_pc & 32'hFFFF_FFFC;
    assign w_pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        pc4_d     = pc4_q;
        inst_d    = inst_q;
        valid_d   = valid_q;

        if (!bus.dcache_stall) begin
            case (state_q)
                S_FETCH: begin
                    if (w_accept) begin
                        pc4_d   = 32'h0;
                        inst_d  = 32'h0;
                        valid_d = 1'b0;
                        if (bus.ICACHE_stall) begin
                            // Wrong-path miss must complete before the PC moves.
                            pend_pc_d = w_target;
                            state_d   = S_DRAIN;
                        end else begin
                            pc_d = w_target;
                        end
                    end else if (bus.ICACHE_stall) begin
                        if (bus.if_id_Write) begin
                            pc4_d   = 32'h0;
                            inst_d  = 32'h0;
                            valid_d = 1'b0;
                        end
                    end else begin
                        if (bus.PCWrite) begin
                            pc_d = w_pc_plus4;
                        end
                        if (bus.if_id_Write) begin
                            pc4_d   = w_pc_plus4;
                            inst_d  = bus.ICACHE_rdata;
                            valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_accept) begin
                        pend_pc_d = w_target;
                    end
                    if (!bus.ICACHE_stall) begin
                        pc_d    = w_accept ? w_target : pend_pc_q;
                        state_d = S_FETCH;
                    end
                    if (bus.if_id_Write) begin
                        pc4_d   = 32'h0;
                        inst_d  = 32'h0;
                        valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'h0;
            pc4_q     <= 32'h0;
            inst_q    <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            pc4_q     <= pc4_d;
            inst_q    <= inst_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.ICACHE_ren     = ~rst;
    assign bus.ICACHE_addr    = pc_q[31:2];
    assign bus.if_id_pc_plus4 = pc4_q;
    assign bus.if_id_inst     = inst_q;
    assign bus.if_id_valid    = valid_q;
    assign bus.if_id_rs       = inst_q[25:21];
    assign bus.if_id_rt       = inst_q[20:16];
    assign bus.opcode_ID      = inst_q[31:26];

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  tb_if_stage
//  Directed scenarios plus randomized traffic checked against a fetch model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_pc, m_pend, m_pc4, m_inst;
    logic        m_valid;
    bit          m_draining;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bubble_m();
        m_pc4 = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
    endtask

    // Applies the stage's per-cycle rules to the inputs present at this edge.
    task automatic model_step();
        logic        take;
        logic [31:0] tgt;
        take = bus.redirect_valid && bus.PCWrite;
        tgt  = {bus.redirect_pc[31:2], 2'b00};
        if (rst) begin
            m_pc = 32'h0; m_pend = 32'h0; m_draining = 0;
            bubble_m();
        end else if (bus.dcache_stall) begin
            // frozen
        end else if (m_draining) begin
            if (take) m_pend = tgt;
            if (!bus.ICACHE_stall) begin
                m_pc = m_pend;
                m_draining = 0;
            end
            if (bus.if_id_Write) bubble_m();
        end else if (take) begin
            bubble_m();
            if (bus.ICACHE_stall) begin
                m_pend = tgt;
                m_draining = 1;
            end else begin
                m_pc = tgt;
            end
        end else if (bus.ICACHE_stall) begin
            if (bus.if_id_Write) bubble_m();
        end else begin
            if (bus.if_id_Write) begin
                m_pc4 = m_pc + 32'd4;
                m_inst = bus.ICACHE_rdata;
                m_valid = 1'b1;
            end
            if (bus.PCWrite) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all();
        logic [31:0] iw;
        iw = m_inst;
        chk("addr",    {2'b00, bus.ICACHE_addr}, {2'b00, m_pc[31:2]});
        chk("ren",     {31'h0, bus.ICACHE_ren}, {31'h0, ~rst});
        chk("pc4",     bus.if_id_pc_plus4, m_pc4);
        chk("inst",    bus.if_id_inst, m_inst);
        chk("valid",   {31'h0, bus.if_id_valid}, {31'h0, m_valid});
        chk("rs",      {27'h0, bus.if_id_rs}, {27'h0, iw[25:21]});
        chk("rt",      {27'h0, bus.if_id_rt}, {27'h0, iw[20:16]});
        chk("opcode",  {26'h0, bus.opcode_ID}, {26'h0, iw[31:26]});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic pcw, input logic idw, input logic dcs,
                         input logic rv, input logic [31:0] rpc, input logic ist);
        bus.PCWrite        = pcw;
        bus.if_id_Write    = idw;
        bus.dcache_stall   = dcs;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.ICACHE_stall   = ist;
        bus.ICACHE_rdata   = $urandom;
    endtask

    logic [31:0] snap_pc4;
    logic [29:0] prev_addr;
    logic        prev_ist;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_pc = 0; m_pend = 0; m_pc4 = 0; m_inst = 0; m_valid = 0; m_draining = 0;
        rst = 1'b1;
        drive(1, 1, 0, 0, 32'h0, 0);

        // Reset
        cycle();
        cycle();
        chk("rst_addr",  {2'b00, bus.ICACHE_addr}, 32'h0);
        chk("rst_ren",   {31'h0, bus.ICACHE_ren}, 32'h0);
        chk("rst_valid", {31'h0, bus.if_id_valid}, 32'h0);
        rst = 1'b0;
        #1;

        // Four back-to-back hits
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 32'h0, 0);
            chk("hit_addr", {2'b00, bus.ICACHE_addr}, i);
            cycle();
            chk("hit_pc4", bus.if_id_pc_plus4, 32'd4 * (i + 1));
            chk("hit_valid", {31'h0, bus.if_id_valid}, 32'h1);
        end

        // Load-use stall holding an lw in IF/ID
        drive(1, 1, 0, 0, 32'h0, 0);
        bus.ICACHE_rdata = 32'h8D09_0000;
        cycle();
        drive(0, 0, 0, 0, 32'h0, 0);
        cycle();
        chk("hold_rs",   {27'h0, bus.if_id_rs}, 32'd8);
        chk("hold_rt",   {27'h0, bus.if_id_rt}, 32'd9);
        chk("hold_addr", {2'b00, bus.ICACHE_addr}, 32'd5);

        // Three-cycle miss at 0x40
        drive(1, 1, 0, 1, 32'h40, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 32'h0, 1);
            cycle();
            chk("miss_addr",  {2'b00, bus.ICACHE_addr}, 32'h10);
            chk("miss_valid", {31'h0, bus.if_id_valid}, 32'h0);
        end
        drive(1, 1, 0, 0, 32'h0, 0);
        cycle();
        chk("miss_done_addr", {2'b00, bus.ICACHE_addr}, 32'h11);
        chk("miss_done_pc4",  bus.if_id_pc_plus4, 32'h44);

        // Redirect on a hit
        drive(1, 1, 0, 1, 32'h10, 0);
        cycle();
        drive(1, 1, 0, 1, 32'h200, 0);
        cycle();
        chk("redir_addr",  {2'b00, bus.ICACHE_addr}, 32'h80);
        chk("redir_valid", {31'h0, bus.if_id_valid}, 32'h0);

        // Redirect during a miss, then a newer redirect while draining
        drive(1, 1, 0, 1, 32'h20, 0);
        cycle();
        drive(1, 1, 0, 1, 32'h300, 1);
        cycle();
        chk("drain_addr0", {2'b00, bus.ICACHE_addr}, 32'h08);
        drive(1, 1, 0, 1, 32'h400, 1);
        cycle();
        chk("drain_addr1", {2'b00, bus.ICACHE_addr}, 32'h08);
        drive(1, 1, 0, 0, 32'h0, 1);
        cycle();
        chk("drain_addr2", {2'b00, bus.ICACHE_addr}, 32'h08);
        drive(1, 1, 0, 0, 32'h0, 0);
        cycle();
        chk("drain_tgt", {2'b00, bus.ICACHE_addr}, 32'h100);
        drive(1, 1, 0, 0, 32'h0, 0);
        cycle();
        chk("drain_fetch", {2'b00, bus.ICACHE_addr}, 32'h101);

        // D-cache stall with a held redirect
        snap_pc4 = bus.if_id_pc_plus4;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 1, 32'h503, (i == 2));
            cycle();
            chk("dcs_addr", {2'b00, bus.ICACHE_addr}, 32'h101);
            chk("dcs_pc4",  bus.if_id_pc_plus4, snap_pc4);
        end
        drive(1, 1, 0, 1, 32'h503, 0);
        cycle();
        chk("dcs_redir", {2'b00, bus.ICACHE_addr}, 32'h140);

        // PC wrap-around
        drive(1, 1, 0, 1, 32'hFFFF_FFFC, 0);
        cycle();
        drive(1, 1, 0, 0, 32'h0, 0);
        cycle();
        chk("wrap_addr", {2'b00, bus.ICACHE_addr}, 32'h0);
        chk("wrap_pc4",  bus.if_id_pc_plus4, 32'h0);

        // Reset while draining discards the pending target
        drive(1, 1, 0, 1, 32'h700, 1);
        cycle();
        rst = 1'b1;
        drive(1, 1, 0, 0, 32'h0, 1);
        cycle();
        rst = 1'b0;
        drive(1, 1, 0, 0, 32'h0, 0);
        cycle();
        chk("rst_drain_addr", {2'b00, bus.ICACHE_addr}, 32'h1);

        // Randomized traffic
        prev_addr = bus.ICACHE_addr;
        prev_ist  = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                  $urandom, $urandom_range(0, 2) == 0);
            prev_addr = bus.ICACHE_addr;
            prev_ist  = bus.ICACHE_stall;
            cycle();
            if (prev_ist && !rst)
                chk("addr_stable", {2'b00, bus.ICACHE_addr}, {2'b00, prev_addr});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
